// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and sizes for the multiply/divide unit
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_DIV   = 2'b01,
        OP_MULTU = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MULT   = 2'b01,
        DIV    = 2'b10,
        FINISH = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - restoring division on unsigned magnitudes, one quotient bit per step
module mdu_div_core import mdu_pkg::*; #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_next,
    output logic [WIDTH-1:0] o_quo_next
);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // Remainder stays below the divisor, so the difference always fits in WIDTH bits when kept.
    assign w_shifted  = {r_rem, r_quo[WIDTH-1]};
    assign w_fits     = (w_shifted >= {1'b0, r_div});
    assign w_diff     = w_shifted[WIDTH-1:0] - r_div;
    assign w_rem_next = w_fits ? w_diff : w_shifted[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};
    assign o_rem_next = w_rem_next;
    assign o_quo_next = w_quo_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - serial MIPS HI/LO multiply/divide unit; MDU_UNSIGNED_EN adds MULTU/DIVU
module mult_div_unit import mdu_pkg::*; #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e       r_state, w_state_next;
    logic [CW-1:0]    r_cnt;
    logic             r_signed, r_div_zero, r_a_neg, r_b_neg;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q, r_m, r_hi, r_lo;
    logic             r_q_1;

    logic             w_signed_in, w_is_div_in, w_op_ok, w_accept, w_b_zero, w_last;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_m_ext, w_mul_sum, w_acc_next;
    logic [WIDTH-1:0] w_q_next, w_rem_next, w_quo_next, w_rem_fix, w_quo_fix;

    assign w_signed_in = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_div_in = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_UNSIGNED_EN
    assign w_op_ok = 1'b1;
`else
    assign w_op_ok = w_signed_in;
`endif
    assign w_accept = start && (r_state == IDLE) && w_op_ok;
    assign w_b_zero = (b_in == '0);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_a_mag  = (w_signed_in && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
    assign w_b_mag  = (w_signed_in && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_state_next = !w_is_div_in ? MULT : (w_b_zero ? FINISH : DIV);
            MULT,
            DIV:      if (w_last) w_state_next = FINISH;
            FINISH:   w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != IDLE);
        done     = (r_state == FINISH);
        div_zero = (r_state == FINISH) && r_div_zero;
    end

    // Booth (signed) or shift-add (unsigned) step; the extra accumulator bit absorbs INT_MIN and carries.
    assign w_m_ext = r_signed ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};
    always_comb begin
        w_mul_sum = r_acc;
        if (r_signed) begin
            if (r_q[0] && !r_q_1)      w_mul_sum = r_acc - w_m_ext;
            else if (!r_q[0] && r_q_1) w_mul_sum = r_acc + w_m_ext;
        end else if (r_q[0]) begin
            w_mul_sum = r_acc + w_m_ext;
        end
    end
    assign w_acc_next = {r_signed ? w_mul_sum[WIDTH] : 1'b0, w_mul_sum[WIDTH:1]};
    assign w_q_next   = {w_mul_sum[0], r_q[WIDTH-1:1]};

    mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_accept),
        .i_step     (r_state == DIV),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_rem_next (w_rem_next),
        .o_quo_next (w_quo_next)
    );

    assign w_quo_fix = (r_signed && (r_a_neg ^ r_b_neg)) ? -w_quo_next : w_quo_next;
    assign w_rem_fix = (r_signed && r_a_neg) ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_signed   <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_neg    <= 1'b0;
            r_b_neg    <= 1'b0;
            r_acc      <= '0;
            r_q        <= '0;
            r_q_1      <= 1'b0;
            r_m        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_signed   <= w_signed_in;
            r_div_zero <= w_is_div_in && w_b_zero;
            r_a_neg    <= w_signed_in && a_in[WIDTH-1];
            r_b_neg    <= w_signed_in && b_in[WIDTH-1];
            r_acc      <= '0;
            r_q        <= a_in;
            r_q_1      <= 1'b0;
            r_m        <= b_in;
        end else if (r_state == MULT) begin
            r_cnt <= r_cnt + CW'(1);
            r_acc <= w_acc_next;
            r_q   <= w_q_next;
            r_q_1 <= r_q[0];
            if (w_last) begin
                r_hi <= w_acc_next[WIDTH-1:0];
                r_lo <= w_q_next;
            end
        end else if (r_state == DIV) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
